dir_input_ctrl: RTL and testbench
=================================

// Module: dir_input_ctrl
// PURPOSE
// - Conditions the five raw pushbuttons (four directions plus restart) for the snake game core.
// - Sits directly upstream of the core's direction FSM, on the same 100 MHz clock.
// - Synchronises and debounces each button and detects presses.
// - Rejects illegal turns (reversal, same-axis) and emits at most one clean one-cycle turn pulse.
// - Mirrors the core's heading so the core sees only legal turns.
// PARAMETERS
// - DEBOUNCE_CYCLES  1000000  consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2
// - CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, not overridden)
// PORTS
// - clk          in   1  system clock, 100 MHz domain of the game core
// - reset        in   1  asynchronous, active-low reset
// - btn_right    in   1  raw pushbutton, asynchronous to clk, active-high
// - btn_left     in   1  raw pushbutton, asynchronous, active-high
// - btn_down     in   1  raw pushbutton, asynchronous, active-high
// - btn_up       in   1  raw pushbutton, asynchronous, active-high
// - btn_restart  in   1  raw pushbutton, asynchronous, active-high
// - right        out  1  one-cycle accepted turn pulse toward the core
// - left         out  1  one-cycle accepted turn pulse
// - down         out  1  one-cycle accepted turn pulse
// - up           out  1  one-cycle accepted turn pulse
// - restart      out  1  one-cycle restart pulse
// - heading      out  2  mirrored heading: r=0, u=1, d=2, l=3
// BEHAVIOUR
// Reset (reset=0, async):
// - All sync flops, stable levels and counters go to 0.
// - right/left/down/up/restart = 0; heading = r (0).
// Sync: each button passes through a 2-FF synchroniser; no logic uses the raw inputs.
// Debounce, per button (independent):
// - While sync != stable: cnt increments each cycle.
// - When cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
// - Any cycle with sync == stable: cnt <= 0, so glitches shorter than DEBOUNCE_CYCLES are discarded.
// - Press event = one cycle where stable rises 0->1. Release produces no event.
// - Holding a button never repeats the event.
// Latency: raw edge -> output pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 (registered output) cycles.
// Arbitration, evaluated each cycle on the press events:
// - A restart event wins: restart=1, heading<=r, and all direction pulses are 0 that cycle.
// - Otherwise the legal set depends on heading:
//   - heading r or l: up and down are legal.
//   - heading u or d: right and left are legal.
// - Illegal events (reversal, same-axis) are dropped silently; nothing is queued.
// - Among simultaneous legal events the priority is up > down > right > left.
// - Exactly one pulse is asserted for 1 cycle, and heading updates on the same edge.
// Outputs:
// - All outputs are registered. The four direction pulses are mutually exclusive and never assert with restart.
// - heading changes only on an accepted pulse, a restart, or reset.
// Reset mid-debounce: the counter and stable level clear, and a held button re-qualifies from zero after release.
// TESTING (run with DEBOUNCE_CYCLES=4)
// 1. Reset:
//    - reset=0 with buttons toggling -> all pulses 0 and heading=0.
//    - Release reset -> no spurious pulse.
// 2. Legal press:
//    - btn_up high for 20 cycles -> up=1 for exactly 1 cycle, 7 cycles after the edge.
//    - heading=1 afterwards; no repeat while held.
// 3. Glitch rejection:
//    - btn_down pulses of 3 cycles, separated by 3 low cycles -> no output, heading unchanged.
// 4. Reversal rejection, starting from heading=r:
//    - press btn_left -> no pulse.
//    - press btn_right -> no pulse.
//    - press btn_down -> down pulse and heading=2.
// 5. Simultaneous press, heading=u:
//    - btn_right and btn_left rise on the same cycle -> right pulse only, heading=0.
// 6. Restart priority, heading=d:
//    - btn_restart and btn_left rise on the same cycle -> restart pulse, no left pulse, heading=0.
//    - Assert reset mid-press -> outputs clear immediately.

Source files
------------

// File: rtl/dir_input_ctrl_if.sv
// Button / pulse bundle between the raw pushbuttons and the snake game core.
// master: the pushbutton side that drives the raw buttons and observes the result.
// slave:  the conditioning block that consumes the buttons and produces pulses.
interface dir_input_ctrl_if;
  // Raw pushbuttons, asynchronous to clk, active-high
  logic       btn_right;
  logic       btn_left;
  logic       btn_down;
  logic       btn_up;
  logic       btn_restart;

  // Accepted one-cycle pulses toward the core
  logic       right;
  logic       left;
  logic       down;
  logic       up;
  logic       restart;

  // Mirrored heading: r=0, u=1, d=2, l=3
  logic [1:0] heading;

  modport master (
    output btn_right, btn_left, btn_down, btn_up, btn_restart,
    input  right, left, down, up, restart, heading
  );

  modport slave (
    input  btn_right, btn_left, btn_down, btn_up, btn_restart,
    output right, left, down, up, restart, heading
  );
endinterface

// File: rtl/dir_input_ctrl.sv
// Pushbutton conditioning for the snake game core: 2-FF synchronise, debounce,
// detect presses, reject illegal turns and emit one registered pulse per
// accepted event while mirroring the core's heading.
module dir_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic          clk,
  input logic          reset,
  dir_input_ctrl_if.slave io
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned NBTN  = 5;

  // Button index map shared by every per-button vector below
  localparam int unsigned B_RIGHT   = 0;
  localparam int unsigned B_LEFT    = 1;
  localparam int unsigned B_DOWN    = 2;
  localparam int unsigned B_UP      = 3;
  localparam int unsigned B_RESTART = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HD_R = 2'd0,
    HD_U = 2'd1,
    HD_D = 2'd2,
    HD_L = 2'd3
  } heading_t;

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  stable;
  logic [NBTN-1:0]  stable_d;
  logic [CNT_W-1:0] cnt [NBTN];
  logic [NBTN-1:0]  press;

  heading_t         heading_q;
  heading_t         heading_n;
  logic [NBTN-1:0]  pulse_q;
  logic [NBTN-1:0]  pulse_n;

  assign raw[B_RIGHT]   = io.btn_right;
  assign raw[B_LEFT]    = io.btn_left;
  assign raw[B_DOWN]    = io.btn_down;
  assign raw[B_UP]      = io.btn_up;
  assign raw[B_RESTART] = io.btn_restart;

  // Two-stage synchroniser; nothing downstream looks at raw
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: level accepted only after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; any agreeing cycle restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced level, for rising-edge (press) detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign press = stable & ~stable_d;

  // Heading state and registered output pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      heading_q <= HD_R;
      pulse_q   <= '0;
    end else begin
      heading_q <= heading_n;
      pulse_q   <= pulse_n;
    end
  end

  // Arbitration: restart wins, otherwise the highest-priority legal turn
  // (up > down > right > left) for the current axis; illegal presses drop
  always_comb begin
    heading_n = heading_q;
    pulse_n   = '0;
    if (press[B_RESTART]) begin
      pulse_n[B_RESTART] = 1'b1;
      heading_n          = HD_R;
    end else begin
      unique case (heading_q)
        HD_R, HD_L: begin
          if (press[B_UP]) begin
            pulse_n[B_UP] = 1'b1;
            heading_n     = HD_U;
          end else if (press[B_DOWN]) begin
            pulse_n[B_DOWN] = 1'b1;
            heading_n       = HD_D;
          end
        end
        HD_U, HD_D: begin
          if (press[B_RIGHT]) begin
            pulse_n[B_RIGHT] = 1'b1;
            heading_n        = HD_R;
          end else if (press[B_LEFT]) begin
            pulse_n[B_LEFT] = 1'b1;
            heading_n       = HD_L;
          end
        end
        default: begin
          heading_n = HD_R;
        end
      endcase
    end
  end

  assign io.right   = pulse_q[B_RIGHT];
  assign io.left    = pulse_q[B_LEFT];
  assign io.down    = pulse_q[B_DOWN];
  assign io.up      = pulse_q[B_UP];
  assign io.restart = pulse_q[B_RESTART];
  assign io.heading = heading_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl with a short debounce window.
module tb_dir_input_ctrl;

  localparam int unsigned DB = 4;

  // Bit order used for button masks and pulse vectors
  localparam logic [4:0] M_R = 5'b00001;
  localparam logic [4:0] M_L = 5'b00010;
  localparam logic [4:0] M_D = 5'b00100;
  localparam logic [4:0] M_U = 5'b01000;
  localparam logic [4:0] M_S = 5'b10000;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  dir_input_ctrl_if bus ();

  dir_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] pulses();
    return {bus.restart, bus.up, bus.down, bus.left, bus.right};
  endfunction

  task automatic set_btns(input logic [4:0] m);
    bus.btn_right   = m[0];
    bus.btn_left    = m[1];
    bus.btn_down    = m[2];
    bus.btn_up      = m[3];
    bus.btn_restart = m[4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Raise buttons in mask, expect exp_p exactly on the 7th edge, hold, release,
  // and confirm nothing more happens and the heading settled to exp_hd
  task automatic press(input string tag, input logic [4:0] m, input logic [4:0] exp_p,
                       input logic [1:0] exp_hd, input int hold);
    to_negedge();
    set_btns(m);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk({tag, "_pre"}, pulses(), 5'b0);
    end
    tick();
    chk({tag, "_pulse"}, pulses(), exp_p);
    for (int i = 8; i <= hold; i++) begin
      tick();
      chk({tag, "_held"}, pulses(), 5'b0);
    end
    to_negedge();
    set_btns(5'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk({tag, "_rel"}, pulses(), 5'b0);
    end
    chk({tag, "_hd"}, {3'b0, bus.heading}, {3'b0, exp_hd});
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    set_btns(5'b0);

    // Reset held while buttons toggle
    for (int i = 0; i < 10; i++) begin
      to_negedge();
      set_btns((i % 2 == 0) ? 5'b11111 : 5'b0);
      tick();
      chk("rst_pulses", pulses(), 5'b0);
      chk("rst_hd", {3'b0, bus.heading}, 5'd0);
    end
    to_negedge();
    set_btns(5'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_rel", pulses(), 5'b0);
    end

    // Legal press from r: up after 7 edges, no repeat during 20-cycle hold
    press("up1", M_U, M_U, 2'd1, 20);

    // Glitches one cycle shorter than the window are discarded
    for (int r = 0; r < 4; r++) begin
      to_negedge();
      set_btns(M_D);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("glitch_hi", pulses(), 5'b0);
      end
      to_negedge();
      set_btns(5'b0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("glitch_lo", pulses(), 5'b0);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_tail", pulses(), 5'b0);
    end
    chk("glitch_hd", {3'b0, bus.heading}, 5'd1);

    // Back to r, then same-axis / reversal rejection
    press("right1", M_R, M_R, 2'd0, 8);
    press("rev_left", M_L, 5'b0, 2'd0, 8);
    press("same_right", M_R, 5'b0, 2'd0, 8);
    press("down1", M_D, M_D, 2'd2, 8);

    // d -> r -> u, then simultaneous right+left: right wins
    press("right2", M_R, M_R, 2'd0, 8);
    press("up2", M_U, M_U, 2'd1, 8);
    press("simul_rl", M_R | M_L, M_R, 2'd0, 8);

    // To d, then restart beats a simultaneous legal left
    press("down2", M_D, M_D, 2'd2, 8);
    press("restart1", M_S | M_L, M_S, 2'd0, 8);

    // Reset while a pulse is on the outputs clears them asynchronously
    to_negedge();
    set_btns(M_U);
    for (int i = 1; i <= 6; i++) tick();
    tick();
    chk("mid_pulse", pulses(), M_U);
    chk("mid_hd", {3'b0, bus.heading}, 5'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_pulses", pulses(), 5'b0);
    chk("async_hd", {3'b0, bus.heading}, 5'd0);
    tick();
    chk("rst_hold", pulses(), 5'b0);

    // Button still held across reset release re-qualifies from zero
    to_negedge();
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("requal_pre", pulses(), 5'b0);
    end
    tick();
    chk("requal_pulse", pulses(), M_U);
    tick();
    chk("requal_after", pulses(), 5'b0);
    chk("requal_hd", {3'b0, bus.heading}, 5'd1);
    to_negedge();
    set_btns(5'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("final_quiet", pulses(), 5'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
